instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Program-feed initiator for the 10-bit processor. It drives the processor's external Data input and timestep-counter enable, and consumes the controller's Clr (instruction-done) as its handshake.
- Holds a small buffer of instruction words, with ld operands stored inline. It issues one instruction at a time and waits for completion before issuing the next.
- Sits between the board switch/host loader and the processor datapath, replacing manual switch entry.

Parameters:
- DEPTH, 16, number of 10-bit program-buffer entries (power of 2).
- AW, 4, pointer width, log2(DEPTH).
- WDOG, 4, max cycles in EXEC without Clr before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  append wr_data to buffer (honoured only in IDLE).
- wr_data  in  10  instruction or ld operand word.
- start  in  1  begin executing buffered program.
- Clr  in  1  instruction-complete pulse from controller.
- Data  out  10  processor external data bus input.
- Peripheral  out  1  timestep counter enable (counter runs while high).
- busy  out  1  high in ISSUE or EXEC.
- done  out  1  one-cycle pulse at end of program or abort.
- err  out  1  sticky; set by overflow, missing operand or watchdog; cleared by rst or accepted start.
- count  out  AW+1  words currently in buffer.

Behaviour:
- Reset values (next edge with rst=1): state=IDLE, pointers=0, count=0, Data=0, Peripheral=0, busy=0, done=0, err=0. rst mid-program aborts immediately; no done pulse.
- Buffer behaviour:
  - wr_en in IDLE with count<DEPTH: mem[wr_ptr]<=wr_data, wr_ptr++ (wraps mod DEPTH), count++.
  - wr_en in IDLE with count==DEPTH: word dropped, err<=1.
  - wr_en outside IDLE: ignored, no err.
- ld detect: word[9:8]==2'b00 and word[3:0]==4'b0000.
- IDLE:
  - Outputs: Data=0, Peripheral=0.
  - start with count==0: done pulse next cycle, stay IDLE.
  - start with count>0: err<=0, go to ISSUE.
  - start and wr_en in the same cycle: the write is applied first, then start is evaluated with the updated count.
- ISSUE (1 cycle, processor at T=0):
  - Outputs: Data=mem[rd_ptr], Peripheral=1.
  - Latch cur=mem[rd_ptr]; rd_ptr++.
  - If cur is ld and rd_ptr+1==wr_ptr (no operand left): err<=1, skip execution, go to FIN.
  - Otherwise go to EXEC, with wd<=0.
- EXEC:
  - Peripheral=1; wd increments each cycle.
  - Data=mem[rd_ptr] (the operand) if cur is ld, else 0.
  - On Clr:
    - If cur is ld, rd_ptr++.
    - If the resulting rd_ptr==wr_ptr, go to FIN; else go to ISSUE.
    - Back-to-back issue: the next ISSUE starts the cycle after Clr.
  - If wd==WDOG-1 with no Clr: err<=1, go to FIN.
- FIN (1 cycle):
  - Outputs: done=1, Peripheral=0, Data=0.
  - Pointers and count reset to 0 (buffer consumed); go to IDLE.
- Outputs are registered.
  - Latency: start accepted at edge N → Data valid and Peripheral=1 from N+1.
  - Clr at edge M → FIN at M+1 on the last instruction.
- Clr outside EXEC: ignored.
- start while busy: ignored.
- Pointer wrap: rd_ptr/wr_ptr wrap mod DEPTH; empty/full are tracked by count, not pointer equality.

Test Plan:
- Load sequence, execute: reset, write 0x000 (ld R0) then 0x155, then 0x061 (cp R1,R0); start; Clr two cycles after each ISSUE → Data=0x000 in the first ISSUE, 0x155 in EXEC, 0x061 in the second ISSUE; done pulses once; count=0; err=0.
- Overflow: write 17 words with DEPTH=16 → count=16, err=1; 17th word absent when executed.
- Missing operand: buffer holds only 0x0C0 (ld R3); start → ISSUE then FIN with no EXEC; err=1; done=1.
- Watchdog: single 0x012 (add); never assert Clr → FIN exactly WDOG cycles after entering EXEC; err=1; Peripheral=0 after FIN.
- Control conflicts: start with count=0 → done only, busy stays 0; wr_en during EXEC ignored (count unchanged); stray Clr in IDLE → no state change.
- Reset mid-operation: rst during EXEC → next cycle all outputs at reset values; no done pulse; a subsequent write plus start behaves normally.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers 10-bit instruction words and feeds them one at a time to the processor, handshaking on Clr.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int WDOG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [9:0]    wr_data,
  input  logic          start,
  input  logic          Clr,
  output logic [9:0]    Data,
  output logic          Peripheral,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);
  localparam int WW = $clog2(WDOG + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, FIN} state_t;
  state_t state, state_n;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic [AW:0] count_n;
  logic [WW-1:0] wd, wd_n;
  logic cur_ld, ld_n, err_n, done_n, wr_fire;
  logic [9:0] word, data_n;

  function automatic logic is_ld(input logic [9:0] w);
    return w[9:8] == 2'b00 && w[3:0] == 4'b0000;
  endfunction

  always_comb begin
    state_n = state;
    rd_n = rd_ptr;
    wr_n = wr_ptr;
    count_n = count;
    wd_n = wd;
    ld_n = cur_ld;
    err_n = err;
    done_n = 1'b0;
    wr_fire = 1'b0;
    case (state)
      IDLE: begin
        wr_fire = wr_en && count != (AW+1)'(DEPTH);
        if (wr_en && !wr_fire) err_n = 1'b1;
        if (wr_fire) begin
          wr_n = wr_ptr + 1'b1;
          count_n = count + 1'b1;
        end
        if (start && count_n == '0) done_n = 1'b1;
        else if (start) begin
          err_n = 1'b0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        ld_n = is_ld(mem[rd_ptr]);
        rd_n = rd_ptr + 1'b1;
        wd_n = '0;
        state_n = (ld_n && rd_n == wr_ptr) ? FIN : EXEC;
        if (ld_n && rd_n == wr_ptr) err_n = 1'b1;
      end
      EXEC: begin
        wd_n = wd + 1'b1;
        if (Clr) begin
          rd_n = rd_ptr + AW'(cur_ld);
          state_n = (rd_n == wr_ptr) ? FIN : ISSUE;
        end else if (wd == WW'(WDOG - 1)) begin
          err_n = 1'b1;
          state_n = FIN;
        end
      end
      FIN: begin
        rd_n = '0;
        wr_n = '0;
        count_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    done_n = done_n || state_n == FIN;
    // forward a same-cycle write so write+start of the first word issues it directly
    word = (wr_fire && wr_ptr == rd_n) ? wr_data : mem[rd_n];
    data_n = (state_n == ISSUE || (state_n == EXEC && ld_n)) ? word : '0;
  end

  always_ff @(posedge clk)
    if (!rst && wr_fire) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      wd <= '0;
      cur_ld <= 1'b0;
      err <= 1'b0;
      done <= 1'b0;
      Data <= '0;
      Peripheral <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      count <= count_n;
      wd <= wd_n;
      cur_ld <= ld_n;
      err <= err_n;
      done <= done_n;
      Data <= data_n;
      Peripheral <= state_n == ISSUE || state_n == EXEC;
      busy <= state_n == ISSUE || state_n == EXEC;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed programs checked by an event scoreboard against a list-walking model.
module tb_instr_sequencer;
  localparam int DEPTH = 16, AW = 4, WDOG = 4;
  localparam logic [1:0] K_ISS = 2'd0, K_EXE = 2'd1, K_DON = 2'd2;
  typedef struct packed {logic [1:0] k; logic [9:0] v;} ev_t;

  logic clk = 1'b0, rst, wr_en, start, auto_clr, stray_clr, Clr;
  logic [9:0] wr_data, Data;
  logic Peripheral, busy, done, err;
  logic [AW:0] count;
  ev_t exp_q[$];
  logic [9:0] mbuf[$];
  int plan[$], dq[$];
  bit merr;
  int tests = 0, fails = 0;

  assign Clr = auto_clr | stray_clr;
  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start), .Clr(Clr),
    .Data(Data), .Peripheral(Peripheral), .busy(busy), .done(done), .err(err), .count(count)
  );

  function automatic bit ld(input logic [9:0] w);
    return w[9:8] == 2'b00 && w[3:0] == 4'b0000;
  endfunction

  function automatic ev_t mk(input logic [1:0] k, input logic [9:0] v);
    ev_t e;
    e.k = k;
    e.v = v;
    return e;
  endfunction

  function automatic logic [9:0] rword();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if ($urandom_range(0, 3) == 0) begin
      w[9:8] = 2'b00;
      w[3:0] = 4'b0000;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mwrite(input logic [9:0] w);
    if (mbuf.size() < DEPTH) mbuf.push_back(w);
    else merr = 1'b1;
  endtask

  task automatic wr(input logic [9:0] w);
    mwrite(w);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  // Walk the buffered word list: each instruction issues, an ld carries its operand into EXEC,
  // and an absent operand or a Clr that never comes ends the program with err.
  task automatic build();
    int n = mbuf.size(), i = 0, k = 0;
    bit fin = 0;
    logic [9:0] w;
    if (n > 0) begin
      merr = 1'b0;
      while (!fin) begin
        w = mbuf[i];
        exp_q.push_back(mk(K_ISS, w));
        if (ld(w) && i == n - 1) begin
          merr = 1'b1;
          fin = 1;
        end else begin
          exp_q.push_back(mk(K_EXE, ld(w) ? mbuf[i+1] : 10'd0));
          if (k >= plan.size() || plan[k] >= WDOG) begin
            merr = 1'b1;
            fin = 1;
          end else begin
            k++;
            i += ld(w) ? 2 : 1;
            fin = i >= n;
          end
        end
      end
    end
    exp_q.push_back(mk(K_DON, {9'd0, merr}));
    mbuf.delete();
  endtask

  task automatic go(input bit with_w, input logic [9:0] w);
    if (with_w) mwrite(w);
    build();
    dq = plan;
    start = 1'b1;
    wr_en = with_w;
    wr_data = w;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic finish_prog(output int c);
    c = 0;
    while (done !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    chk("done_seen", done, 1);
    tick();
    chk("count_after", count, 0);
    chk("err_after", err, merr);
    chk("per_after", Peripheral, 0);
  endtask

  task automatic rand_plan();
    plan.delete();
    for (int i = 0; i < DEPTH; i++) plan.push_back($urandom_range(0, 11) == 0 ? 9 : $urandom_range(0, WDOG - 1));
  endtask

  // Clr responder: pulses Clr after plan[k] EXEC cycles of the k-th executed instruction.
  initial begin
    bit pq, iss;
    int ec;
    auto_clr = 1'b0;
    pq = 1'b0;
    ec = 0;
    forever begin
      @(posedge clk);
      #1;
      iss = Peripheral && (!pq || auto_clr);
      if (iss) ec = -1;
      else if (Peripheral) ec++;
      auto_clr = Peripheral && !iss && dq.size() > 0 && ec == dq[0];
      if (auto_clr) void'(dq.pop_front());
      pq = Peripheral;
    end
  end

  bit mp = 0, mc = 0, mi = 0;
  always @(negedge clk) begin : mon
    ev_t g, e;
    bit have, iss;
    iss = Peripheral && (!mp || mc);
    tests++;
    if (busy !== Peripheral) begin
      fails++;
      $display("FAIL busy_vs_per: busy %b Peripheral %b", busy, Peripheral);
    end
    have = 0;
    g = '0;
    if (iss) begin
      g = mk(K_ISS, Data);
      have = 1;
    end else if (Peripheral && mi) begin
      g = mk(K_EXE, Data);
      have = 1;
    end else if (done) begin
      g = mk(K_DON, {9'd0, err});
      have = 1;
      tests++;
      if (Data !== 10'd0 || Peripheral !== 1'b0) begin
        fails++;
        $display("FAIL done_outputs: Data %h Peripheral %b want 0 0", Data, Peripheral);
      end
    end
    if (have) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got kind %0d val %h, none expected", g.k, g.v);
      end else begin
        e = exp_q.pop_front();
        if (e !== g) begin
          fails++;
          $display("FAIL event: got kind %0d val %h expected kind %0d val %h", g.k, g.v, e.k, e.v);
        end
      end
    end
    mi = iss;
    mp = Peripheral;
    mc = Clr;
  end

  initial begin
    int c;
    rst = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    stray_clr = 1'b0;
    wr_data = '0;
    merr = 1'b0;
    tick();
    tick();
    chk("rst_data", Data, 0);
    chk("rst_per", Peripheral, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    tick();
    wr(10'h000);
    wr(10'h155);
    wr(10'h061);
    chk("load_count", count, 3);
    plan = '{1, 1};
    go(0, '0);
    finish_prog(c);
    for (int i = 0; i < 17; i++) wr(rword());
    chk("ovf_count", count, 16);
    chk("ovf_err", err, 1);
    rand_plan();
    go(0, '0);
    finish_prog(c);
    wr(10'h0C0);
    plan.delete();
    go(0, '0);
    finish_prog(c);
    chk("missing_op_lat", c, 1);
    wr(10'h012);
    plan = '{99};
    go(0, '0);
    finish_prog(c);
    chk("wdog_lat", c, WDOG + 1);
    go(0, '0);
    finish_prog(c);
    chk("empty_start_lat", c, 0);
    plan = '{0};
    go(1, 10'h012);
    finish_prog(c);
    wr(10'h012);
    plan = '{WDOG - 1};
    go(0, '0);
    tick();
    wr_en = 1'b1;
    wr_data = 10'h3FF;
    tick();
    wr_en = 1'b0;
    chk("wr_in_exec_count", count, 1);
    chk("wr_in_exec_err", err, 0);
    finish_prog(c);
    wr(10'h155);
    stray_clr = 1'b1;
    tick();
    stray_clr = 1'b0;
    chk("stray_clr_count", count, 1);
    chk("stray_clr_busy", busy, 0);
    plan = '{2};
    go(0, '0);
    finish_prog(c);
    wr(10'h012);
    plan = '{99};
    go(0, '0);
    tick();
    tick();
    chk("pre_rst_pending", exp_q.size(), 1);
    exp_q.delete();
    dq.delete();
    merr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_data", Data, 0);
    chk("midrst_per", Peripheral, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", count, 0);
    repeat (3) tick();
    wr(10'h040);
    wr(10'h2AA);
    plan = '{1};
    go(0, '0);
    finish_prog(c);
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      rand_plan();
      for (int i = 0; i < n - 1; i++) wr(rword());
      if ($urandom_range(0, 1) == 1) go(1, rword());
      else begin
        wr(rword());
        go(0, '0);
      end
      finish_prog(c);
    end
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
